compare_sequencer: RTL and testbench

COMPARE_SEQUENCER -- requirements
Module: compare_sequencer

---
 rtl/compare_sequencer.sv | 145 ++++++++++++++
 tb/tb_compare_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/compare_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : compare_sequencer
// Description : Serial unsigned magnitude comparator. Operands are captured
//               on an accepted start and compared one bit per cycle, MSB
//               first. The first differing bit decides the result.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : compare request, sampled only in IDLE
//   input1       : operand A (WIDTH bits)
//   input2       : operand B (WIDTH bits)
//   busy         : high while scanning
//   done         : one-cycle pulse when eq/gt/lt are freshly valid
//   eq / gt / lt : A==B / A>B / A<B (unsigned), held until the next done
// Configuration
//   COMPARE_SEQUENCER_EARLY_EXIT_EN : when defined, the scan stops on the
//                                     first differing bit.
// ============================================================================
module compare_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int         c_IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_IW-1:0] c_IDX_MSB = c_IW'(WIDTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SCAN = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [c_IW-1:0]  r_idx;
  logic             r_flag;
  logic             r_fgt;
  logic             r_flt;

  logic             w_bit_a;
  logic             w_bit_b;
  logic             w_diff;
  logic             w_first;
  logic             w_last;
  logic             w_res_flag;
  logic             w_res_gt;
  logic             w_res_lt;

  assign w_bit_a = r_a[r_idx];
  assign w_bit_b = r_b[r_idx];
  assign w_diff  = w_bit_a ^ w_bit_b;
  // Only the first differing bit may set the sticky flag.
  assign w_first = w_diff & ~r_flag;

`ifdef COMPARE_SEQUENCER_EARLY_EXIT_EN
  assign w_last = (r_idx == '0) | w_first;
`else
  assign w_last = (r_idx == '0);
`endif

  // Result as it stands after evaluating the current bit; used so the
  // outputs reflect a difference found in the very cycle SCAN ends.
  assign w_res_flag = r_flag | w_diff;
  assign w_res_gt   = r_flag ? r_fgt : w_bit_a;
  assign w_res_lt   = r_flag ? r_flt : w_bit_b;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (start)  w_state_nxt = c_SCAN;
      c_SCAN:  if (w_last) w_state_nxt = c_DONE;
      c_DONE:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (r_state == c_SCAN);
    done = (r_state == c_DONE);
  end

  // Datapath: shadow operands, bit index, sticky difference and results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_idx  <= '0;
      r_flag <= 1'b0;
      r_fgt  <= 1'b0;
      r_flt  <= 1'b0;
      eq     <= 1'b0;
      gt     <= 1'b0;
      lt     <= 1'b0;
    end else begin
      if ((r_state == c_IDLE) && start) begin
        r_a    <= input1;
        r_b    <= input2;
        r_idx  <= c_IDX_MSB;
        r_flag <= 1'b0;
        r_fgt  <= 1'b0;
        r_flt  <= 1'b0;
      end else if (r_state == c_SCAN) begin
        if (w_first) begin
          r_flag <= 1'b1;
          r_fgt  <= w_bit_a;
          r_flt  <= w_bit_b;
        end
        if (r_idx != '0) begin
          r_idx <= r_idx - 1'b1;
        end
        if (w_last) begin
          eq <= ~w_res_flag;
          gt <= w_res_flag & w_res_gt;
          lt <= w_res_flag & w_res_lt;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_compare_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_compare_sequencer
// Description : Directed, table-driven bench for compare_sequencer (WIDTH=8)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_compare_sequencer;

  localparam int WIDTH = 8;
`ifdef COMPARE_SEQUENCER_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  int checks = 0;
  int errors = 0;

  compare_sequencer #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .input1 (input1),
    .input2 (input2),
    .busy   (busy),
    .done   (done),
    .eq     (eq),
    .gt     (gt),
    .lt     (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       e_eq;
    logic       e_gt;
    logic       e_lt;
    int         lat_ee;
    int         lat_full;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input int lat_ee, input int lat_full);
    return EE ? lat_ee : lat_full;
  endfunction

  // Issue one compare. Called at #1 after an edge with the DUT in IDLE.
  // Cycle n is the period following the n-th edge after the capture edge.
  task automatic run_compare(input logic [7:0] a, input logic [7:0] b,
                             output int lat, output int ndone);
    input1 = a;
    input2 = b;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = -1;
    ndone = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (done) begin
        ndone++;
        if (lat < 0) lat = cyc;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lat;
    int nd;
    int second_lat;

    vecs[0] = '{8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 9, 9};
    vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 2, 9};
    vecs[2] = '{8'h01, 8'h03, 1'b0, 1'b0, 1'b1, 8, 9};
    vecs[3] = '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 2, 9};
    vecs[4] = '{8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 9, 9};
    vecs[5] = '{8'h0F, 8'h0E, 1'b0, 1'b1, 1'b0, 9, 9};

    rst_n  = 1'b0;
    start  = 1'b0;
    input1 = '0;
    input2 = '0;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_eq",   int'(eq),   0);
    chk("reset_gt",   int'(gt),   0);
    chk("reset_lt",   int'(lt),   0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven compares
    foreach (vecs[i]) begin
      run_compare(vecs[i].a, vecs[i].b, lat, nd);
      chk($sformatf("v%0d_eq", i), int'(eq), int'(vecs[i].e_eq));
      chk($sformatf("v%0d_gt", i), int'(gt), int'(vecs[i].e_gt));
      chk($sformatf("v%0d_lt", i), int'(lt), int'(vecs[i].e_lt));
      chk($sformatf("v%0d_latency", i), lat, exp_lat(vecs[i].lat_ee, vecs[i].lat_full));
      chk($sformatf("v%0d_done_pulses", i), nd, 1);
    end

    // Inputs change and start pulses during SCAN: neither may matter
    input1 = 8'h10;
    input2 = 8'h00;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    input1 = 8'h00;
    input2 = 8'hFF;
    lat = -1;
    nd  = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 1) chk("scan_busy", int'(busy), 1);
      start = (cyc == 3);
      if (done) begin
        nd++;
        if (lat < 0) lat = cyc;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("ignore_gt", int'(gt), 1);
    chk("ignore_lt", int'(lt), 0);
    chk("ignore_done_pulses", nd, 1);
    chk("ignore_latency", lat, exp_lat(5, 9));
    chk("ignore_idle_busy", int'(busy), 0);

    // Reset mid-SCAN at cycle 4
    input1 = 8'h01;
    input2 = 8'h01;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("areset_busy", int'(busy), 0);
    chk("areset_done", int'(done), 0);
    chk("areset_eq",   int'(eq),   0);
    chk("areset_gt",   int'(gt),   0);
    chk("areset_lt",   int'(lt),   0);
    nd = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 2) rst_n = 1'b1;
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    run_compare(8'h00, 8'hFF, lat, nd);
    chk("post_reset_lt", int'(lt), 1);
    chk("post_reset_eq", int'(eq), 0);
    chk("post_reset_latency", lat, exp_lat(2, 9));

    // Back-to-back: start held through DONE and the following IDLE cycle
    input1 = 8'h33;
    input2 = 8'h44;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
      if (done) lat = cyc;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("b2b_first_latency", lat, exp_lat(3, 9));
    chk("b2b_first_lt", int'(lt), 1);
    input1 = 8'h99;
    input2 = 8'h11;
    start  = 1'b1;
    @(posedge clk); #1;
    chk("b2b_idle_busy", int'(busy), 0);
    chk("b2b_idle_done", int'(done), 0);
    @(posedge clk); #1;
    start = 1'b0;
    second_lat = -1;
    nd = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (cyc == 1) begin
        chk("b2b_second_busy", int'(busy), 1);
        chk("b2b_hold_lt", int'(lt), 1);
        chk("b2b_hold_gt", int'(gt), 0);
      end
      if (done) begin
        nd++;
        if (second_lat < 0) second_lat = cyc;
      end
      @(posedge clk); #1;
    end
    chk("b2b_second_latency", second_lat, exp_lat(2, 9));
    chk("b2b_second_pulses", nd, 1);
    chk("b2b_second_gt", int'(gt), 1);
    chk("b2b_second_lt", int'(lt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
